// File: rtl/denetim_durum_birimi_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : denetim_durum_birimi_p_if
//  Purpose  : Signal bundle between the pipeline datapath and the pipeline
//             control/hazard unit (denetim_durum_birimi_p).
//  Ports    : slave  - the control unit: takes hazard/flush sources, drives
//                      forwarding selectors, stall/bubble masks, valid bits
//                      and the load-use bubble counter.
//             master - the datapath side (mirror of slave).
//  Revision : 1.0  initial release
// ============================================================================
interface denetim_durum_birimi_p_if #(
  parameter int KAYNAK    = 2,
  parameter int RS_SAYISI = 2,
  parameter int SAYAC_BIT = 16
);
  localparam int ASAMA = KAYNAK + 2;
  localparam int YW    = $clog2(KAYNAK + 1);

  logic                      gtr_yanlis_tahmin_i;
  logic                      yrt_istisna_i;
  logic                      gtr_hazir_i;
  logic [RS_SAYISI*5-1:0]    cyo_rs_adres_i;
  logic [KAYNAK*5-1:0]       kaynak_rd_adres_i;
  logic [KAYNAK-1:0]         kaynak_yaz_yazmac_i;
  logic [KAYNAK-1:0]         kaynak_hazir_i;
  logic                      yrt_bellek_oku_i;
  logic [RS_SAYISI*YW-1:0]   cyo_yonlendir_o;
  logic [ASAMA-1:0]          durdur_o;
  logic [ASAMA-1:0]          bosalt_o;
  logic [ASAMA-1:0]          gecerli_o;
  logic [SAYAC_BIT-1:0]      yb_sayac_o;

  modport slave (
    input  gtr_yanlis_tahmin_i, yrt_istisna_i, gtr_hazir_i, cyo_rs_adres_i,
           kaynak_rd_adres_i, kaynak_yaz_yazmac_i, kaynak_hazir_i, yrt_bellek_oku_i,
    output cyo_yonlendir_o, durdur_o, bosalt_o, gecerli_o, yb_sayac_o
  );

  modport master (
    output gtr_yanlis_tahmin_i, yrt_istisna_i, gtr_hazir_i, cyo_rs_adres_i,
           kaynak_rd_adres_i, kaynak_yaz_yazmac_i, kaynak_hazir_i, yrt_bellek_oku_i,
    input  cyo_yonlendir_o, durdur_o, bosalt_o, gecerli_o, yb_sayac_o
  );
endinterface
`default_nettype wire

// File: rtl/denetim_durum_birimi_p.sv
`default_nettype none
// ============================================================================
//  Module   : denetim_durum_birimi_p
//  Purpose  : Pipeline control unit. Produces per-stage hold (durdur) and
//             bubble (bosalt) masks, tracks per-stage valid bits, selects
//             operand forwarding sources for the decode stage, detects
//             load-use hazards and counts inserted load-use bubbles.
//             Stages: 0 GETIR, 1 COZ, 2 YURUT ... KAYNAK+1 GERIYAZ.
//  Ports    : clk_i   - clock, rising edge
//             rst_ni  - asynchronous active-low reset
//             bus     - denetim_durum_birimi_p_if.slave (hazard inputs,
//                       forwarding/stall/bubble/valid/counter outputs)
//  Revision : 1.0  initial release
// ============================================================================
module denetim_durum_birimi_p #(
  parameter int KAYNAK           = 2,
  parameter int RS_SAYISI        = 2,
  parameter int BASLANGIC_CEVRIM = 1,
  parameter int SAYAC_BIT        = 16
) (
  input wire                      clk_i,
  input wire                      rst_ni,
  denetim_durum_birimi_p_if.slave bus
);
  localparam int                   ASAMA        = KAYNAK + 2;
  localparam int                   YW           = $clog2(KAYNAK + 1);
  localparam logic [7:0]           C_BASLANGIC  = 8'(BASLANGIC_CEVRIM);
  localparam logic [SAYAC_BIT-1:0] C_SAYAC_DOLU = '1;

  logic [ASAMA-1:0]        r_gecerli;
  logic [7:0]              r_baslangic;
  logic [SAYAC_BIT-1:0]    r_yb_sayac;

  logic                    w_bekle;
  logic                    w_rs_eslesme;
  logic                    w_lu;
  logic [ASAMA-1:0]        w_mesgul;
  logic [ASAMA-1:0]        w_durdur;
  logic [ASAMA-1:0]        w_bosalt;
  logic [ASAMA-1:0]        w_gecerli_sonraki;
  logic [RS_SAYISI*YW-1:0] w_yonlendir;

  assign w_bekle = (r_baslangic != 8'd0);

  // Load-use: the load sitting in YURUT produces rd too late for any rs
  // being read in COZ this cycle.
  always_comb begin
    w_rs_eslesme = 1'b0;
    for (int r = 0; r < RS_SAYISI; r++) begin
      if (bus.cyo_rs_adres_i[5*r +: 5] == bus.kaynak_rd_adres_i[4:0]) begin
        w_rs_eslesme = 1'b1;
      end
    end
  end

  assign w_lu = r_gecerli[2] & bus.kaynak_yaz_yazmac_i[0] & bus.yrt_bellek_oku_i &
                (bus.kaynak_rd_adres_i[4:0] != 5'd0) & w_rs_eslesme;

  // w_mesgul[j] (j >= 2): some stage at or after j cannot advance. A busy
  // stage back-pressures everything in front of it, hence the suffix OR.
  always_comb begin
    logic v_acc;
    w_mesgul = '0;
    v_acc    = 1'b0;
    for (int j = ASAMA - 1; j >= 2; j--) begin
      v_acc       = v_acc | ~bus.kaynak_hazir_i[j-2];
      w_mesgul[j] = v_acc;
    end
  end

  always_comb begin
    w_durdur    = '0;
    w_bosalt    = '0;
    w_durdur[0] = w_mesgul[2] | w_lu;
    w_durdur[1] = w_mesgul[2] | w_lu;
    for (int i = 2; i < ASAMA; i++) begin
      w_durdur[i] = w_mesgul[i];
    end

    // A stage gets a bubble when it advances but its upstream holds;
    // COZ also takes one when GETIR has nothing to hand over.
    w_bosalt[0] = w_bekle | bus.gtr_yanlis_tahmin_i | bus.yrt_istisna_i;
    w_bosalt[1] = w_bekle | bus.gtr_yanlis_tahmin_i | bus.yrt_istisna_i |
                  (~w_durdur[1] & (w_durdur[0] | ~bus.gtr_hazir_i));
    w_bosalt[2] = w_bekle | bus.yrt_istisna_i | (w_durdur[1] & ~w_durdur[2]);
    for (int i = 3; i < ASAMA; i++) begin
      w_bosalt[i] = w_bekle | (w_durdur[i-1] & ~w_durdur[i]);
    end
  end

  // Bubble wins over hold for the same stage.
  always_comb begin
    w_gecerli_sonraki = '0;
    if (w_bosalt[0])      w_gecerli_sonraki[0] = 1'b0;
    else if (w_durdur[0]) w_gecerli_sonraki[0] = r_gecerli[0];
    else                  w_gecerli_sonraki[0] = 1'b1;
    for (int i = 1; i < ASAMA; i++) begin
      if (w_bosalt[i])      w_gecerli_sonraki[i] = 1'b0;
      else if (w_durdur[i]) w_gecerli_sonraki[i] = r_gecerli[i];
      else                  w_gecerli_sonraki[i] = r_gecerli[i-1];
    end
  end

  // Forwarding: the youngest producer (smallest k) wins, so scan from the
  // oldest down and let later hits overwrite. x0 never forwards.
  always_comb begin
    logic [YW-1:0] v_sec;
    w_yonlendir = '0;
    for (int r = 0; r < RS_SAYISI; r++) begin
      v_sec = '0;
      for (int k = KAYNAK - 1; k >= 0; k--) begin
        if (r_gecerli[k+2] && bus.kaynak_yaz_yazmac_i[k] &&
            (bus.kaynak_rd_adres_i[5*k +: 5] == bus.cyo_rs_adres_i[5*r +: 5]) &&
            (bus.cyo_rs_adres_i[5*r +: 5] != 5'd0)) begin
          v_sec = YW'(k + 1);
        end
      end
      w_yonlendir[r*YW +: YW] = v_sec;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gecerli   <= '0;
      r_baslangic <= C_BASLANGIC;
      r_yb_sayac  <= '0;
    end else begin
      r_gecerli <= w_gecerli_sonraki;
      if (w_bekle) begin
        r_baslangic <= r_baslangic - 8'd1;
      end
      // Only count when the bubble really enters YURUT this cycle.
      if (w_lu && !w_durdur[2] && (r_yb_sayac != C_SAYAC_DOLU)) begin
        r_yb_sayac <= r_yb_sayac + SAYAC_BIT'(1);
      end
    end
  end

  assign bus.cyo_yonlendir_o = w_yonlendir;
  assign bus.durdur_o        = w_durdur;
  assign bus.bosalt_o        = w_bosalt;
  assign bus.gecerli_o       = r_gecerli;
  assign bus.yb_sayac_o      = r_yb_sayac;
endmodule
`default_nettype wire

// File: tb/tb_denetim_durum_birimi_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_denetim_durum_birimi_p
//  Purpose  : Scoreboard bench for denetim_durum_birimi_p (KAYNAK=2,
//             RS_SAYISI=2, BASLANGIC_CEVRIM=3, SAYAC_BIT=4). Directed
//             scenarios followed by random traffic against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_denetim_durum_birimi_p;
  localparam int K  = 2;
  localparam int R  = 2;
  localparam int B  = 3;
  localparam int S  = 4;
  localparam int A  = K + 2;
  localparam int YW = $clog2(K + 1);

  typedef struct {
    logic [R*YW-1:0] fwd;
    logic [A-1:0]    dur;
    logic [A-1:0]    bos;
    logic [A-1:0]    gec;
    logic [S-1:0]    yb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  // reference model state
  int m_gec[A];
  int m_cnt;
  int m_yb;

  always #5 clk = ~clk;

  denetim_durum_birimi_p_if #(.KAYNAK(K), .RS_SAYISI(R), .SAYAC_BIT(S)) bus ();

  denetim_durum_birimi_p #(
    .KAYNAK(K), .RS_SAYISI(R), .BASLANGIC_CEVRIM(B), .SAYAC_BIT(S)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // monitor: outputs are settled 2 time units after the input-change edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("yonlendir", 16'(bus.cyo_yonlendir_o), 16'(e.fwd));
        chk("durdur",    16'(bus.durdur_o),        16'(e.dur));
        chk("bosalt",    16'(bus.bosalt_o),        16'(e.bos));
        chk("gecerli",   16'(bus.gecerli_o),       16'(e.gec));
        chk("yb_sayac",  16'(bus.yb_sayac_o),      16'(e.yb));
      end
    end
  end

  function automatic int rd_of(int k);
    logic [K*5-1:0] v;
    v = bus.kaynak_rd_adres_i;
    return int'(v[5*k +: 5]);
  endfunction

  function automatic int rs_of(int r);
    logic [R*5-1:0] v;
    v = bus.cyo_rs_adres_i;
    return int'(v[5*r +: 5]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < A; i++) m_gec[i] = 0;
    m_cnt = B;
    m_yb  = 0;
  endtask

  // Called just after inputs are driven at a falling edge.
  task automatic step();
    exp_t e;
    bit   lu, hit, bekle;
    int   busy_top, sel;
    bit   dur[A];
    bit   bos[A];
    int   nxt[A];
    #1;
    if (!rst_n) model_reset();
    bekle = (m_cnt != 0);
    hit = 0;
    for (int r = 0; r < R; r++) if (rs_of(r) == rd_of(0)) hit = 1;
    lu = (m_gec[2] != 0) && bus.kaynak_yaz_yazmac_i[0] && bus.yrt_bellek_oku_i &&
         (rd_of(0) != 0) && hit;
    // furthest stage that cannot advance; everything up to it must hold
    busy_top = -1;
    for (int j = 2; j < A; j++) if (!bus.kaynak_hazir_i[j-2]) busy_top = j;
    for (int i = 0; i < A; i++) dur[i] = (i <= busy_top) || (i <= 1 && lu);
    for (int i = 0; i < A; i++) begin
      if (i == 0)      bos[i] = bekle || bus.gtr_yanlis_tahmin_i || bus.yrt_istisna_i;
      else if (i == 1) bos[i] = bekle || bus.gtr_yanlis_tahmin_i || bus.yrt_istisna_i ||
                                (!dur[1] && (dur[0] || !bus.gtr_hazir_i));
      else if (i == 2) bos[i] = bekle || bus.yrt_istisna_i || (dur[1] && !dur[2]);
      else             bos[i] = bekle || (dur[i-1] && !dur[i]);
    end
    e.fwd = '0;
    for (int r = 0; r < R; r++) begin
      sel = 0;
      for (int k = 0; k < K; k++) begin
        if (sel == 0 && m_gec[k+2] != 0 && bus.kaynak_yaz_yazmac_i[k] &&
            rd_of(k) == rs_of(r) && rs_of(r) != 0) sel = k + 1;
      end
      e.fwd[r*YW +: YW] = YW'(sel);
    end
    for (int i = 0; i < A; i++) begin
      e.dur[i] = dur[i];
      e.bos[i] = bos[i];
      e.gec[i] = (m_gec[i] != 0);
    end
    e.yb = S'(m_yb);
    q.push_back(e);
    for (int i = 0; i < A; i++) begin
      if (bos[i])      nxt[i] = 0;
      else if (dur[i]) nxt[i] = m_gec[i];
      else             nxt[i] = (i == 0) ? 1 : m_gec[i-1];
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < A; i++) m_gec[i] = nxt[i];
      if (m_cnt > 0) m_cnt--;
      if (lu && !dur[2] && m_yb < (1 << S) - 1) m_yb++;
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.gtr_yanlis_tahmin_i = 1'b0;
    bus.yrt_istisna_i       = 1'b0;
    bus.gtr_hazir_i         = 1'b1;
    bus.cyo_rs_adres_i      = '0;
    bus.kaynak_rd_adres_i   = '0;
    bus.kaynak_yaz_yazmac_i = '0;
    bus.kaynak_hazir_i      = '1;
    bus.yrt_bellek_oku_i    = 1'b0;
  endtask

  task automatic load_use();
    idle();
    bus.kaynak_rd_adres_i   = {5'd0, 5'd7};
    bus.kaynak_yaz_yazmac_i = 2'b01;
    bus.yrt_bellek_oku_i    = 1'b1;
    bus.cyo_rs_adres_i      = {5'd7, 5'd3};
  endtask

  initial begin
    model_reset();
    idle();
    @(negedge clk);
    // held in reset, including a busy stage
    rst_n = 1'b0;
    step();
    bus.kaynak_hazir_i = 2'b01;
    step();
    idle();
    // release: startup flush then fill
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    // forwarding priority
    bus.cyo_rs_adres_i      = {5'd0, 5'd5};
    bus.kaynak_rd_adres_i   = {5'd5, 5'd5};
    bus.kaynak_yaz_yazmac_i = 2'b11;
    step();
    bus.yrt_istisna_i = 1'b1;
    step();
    bus.yrt_istisna_i = 1'b0;
    step();
    bus.cyo_rs_adres_i = '0;
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    // load-use
    load_use();
    step();
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    // multi-cycle op in YURUT
    bus.kaynak_hazir_i = 2'b10;
    for (int i = 0; i < 4; i++) step();
    idle();
    for (int i = 0; i < 3; i++) step();
    // mispredict together with exception
    bus.gtr_yanlis_tahmin_i = 1'b1;
    bus.yrt_istisna_i       = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
    // reset in the middle of a stall
    bus.kaynak_hazir_i = 2'b10;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 6; i++) step();
    // counter saturation
    load_use();
    for (int i = 0; i < 44; i++) step();
    // random traffic
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.gtr_yanlis_tahmin_i = ($urandom_range(0, 7) == 0);
      bus.yrt_istisna_i       = ($urandom_range(0, 15) == 0);
      bus.gtr_hazir_i         = ($urandom_range(0, 7) != 0);
      bus.cyo_rs_adres_i      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.kaynak_rd_adres_i   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.kaynak_yaz_yazmac_i = 2'($urandom_range(0, 3));
      bus.kaynak_hazir_i      = {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0)};
      bus.yrt_bellek_oku_i    = 1'($urandom_range(0, 1));
      step();
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) @(negedge clk);
    end
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
